load_hazard_scoreboard: RTL and testbench
=========================================

# load_hazard_scoreboard

- Tracks destination registers of in-flight loads, whose results the EX-stage forwarding path cannot supply in time.
- Holds the instruction in ID (stall) while a source or destination register has an outstanding load write.
- Releases the stall when the memory/writeback stage retires that load.
- Sits between decode and the ID/EX pipeline register; it is the producer-side interlock that complements EX-stage operand forwarding.

## Interface

Parameters:
- REG_COUNT, 32, number of architectural integer registers; register 0 is hardwired zero.
- REG_ADDR_WIDTH, 5, register index width.
- MAX_OUTSTANDING, 4, maximum loads in flight; power of two not required, 1..15.
- STALL_CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous reset, active-low.
- in_issue_valid  in  1  ID holds a valid instruction this cycle.
- in_rs1  in  REG_ADDR_WIDTH  first source register of the ID instruction.
- in_rs2  in  REG_ADDR_WIDTH  second source register of the ID instruction.
- in_rs1_used, in_rs2_used  in  1 each  the instruction actually reads that source.
- in_rd  in  REG_ADDR_WIDTH  destination register of the ID instruction.
- in_reg_write  in  1  the ID instruction writes in_rd.
- in_is_load  in  1  the ID instruction is a load.
- in_flush  in  1  squash the ID instruction (branch redirect); it does not issue.
- in_wb_valid  in  1  a load is retiring from MEM/WB this cycle.
- in_wb_rd  in  REG_ADDR_WIDTH  destination register of the retiring load.
- out_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- out_pending  out  REG_COUNT  registered pending-load bit vector; bit 0 is always 0.
- out_outstanding  out  4  registered number of loads in flight.
- out_full  out  1  out_outstanding == MAX_OUTSTANDING.
- out_stall_cycles  out  STALL_CNT_WIDTH  saturating count of cycles with out_stall high.
- out_error  out  1  sticky: a writeback arrived for a non-pending register, or there was an underflow.

## Operation

Hazard detection:
- Combinational from the registered state only.
- hazard = (rs1_used && rs1 != 0 && pending[rs1]) || (rs2_used && rs2 != 0 && pending[rs2]) || (reg_write && rd != 0 && pending[rd]) || (is_load && out_full).
- The rd term is the WAW check; the out_full term is the capacity check.
- out_stall = in_issue_valid && !in_flush && hazard.

Issue and retire:
- accept = in_issue_valid && !in_flush && !hazard.
- set event: accept && in_is_load && in_reg_write && in_rd != 0 sets pending[in_rd] and increments the outstanding count.
- A load with rd == 0 is not tracked.
- clear event: in_wb_valid && in_wb_rd != 0 clears pending[in_wb_rd] and decrements the count.
- If a writeback targets rd == 0 or a non-pending register: no state change; out_error is set (sticky until reset).

Simultaneous events:
- Set and clear in the same cycle leave the count unchanged.
- Set and clear cannot target the same register in the same cycle: the WAW term stalls issue to a pending rd.
- Writeback does not bypass the stall. A register cleared in cycle N releases the stall in cycle N+1, and the forwarding path then supplies the value.
- in_flush has priority over hazard: a flushed instruction neither stalls nor sets state.
- Loads already in flight are never cancelled; they always retire through writeback.

Stall counter:
- out_stall_cycles increments on every cycle with out_stall = 1.
- It saturates at all-ones.

## Timing

- Reset (reset low, asynchronous): pending = 0, out_outstanding = 0, out_full = 0, out_stall_cycles = 0, out_error = 0.
- During reset, out_stall = 0 because pending is 0, except for the capacity term, which is also 0.
- State updates on the rising edge of clk.
- out_stall has zero latency: it is combinational in the same cycle as the ID inputs.
- Issue-to-pending latency: 1 cycle (visible in out_pending the next cycle).
- Writeback-to-release latency: 1 cycle.
- Reset asserted mid-operation discards all pending state immediately. A writeback arriving after reset deasserts for a pre-reset load sets out_error.
- The outstanding count never exceeds MAX_OUTSTANDING (guaranteed by the capacity stall) and never underflows (an underflow attempt is an error case: count holds, out_error set).

## Test plan

- Load-use: issue load x5 (accepted), next cycle issue add x6,x5,x1 -> out_stall = 1. Writeback x5 in cycle 3 -> out_stall = 1 in cycle 3, 0 in cycle 4. out_stall_cycles = 2.
- Capacity with MAX_OUTSTANDING = 4: loads to x1..x4 accepted -> out_full = 1. A fifth load to x7 stalls. Writeback x2 -> fifth load accepted the following cycle; out_outstanding returns to 4.
- Zero register and unused sources: load x0 -> no pending bit, count 0. Instruction with rs2 = x3 pending but rs2_used = 0 -> no stall.
- WAW and flush: x9 pending. Issue load x9 -> stall. Same inputs with in_flush = 1 -> out_stall = 0 and no state change. Simultaneous set x10 and clear x9 -> count unchanged, pending = {x10}.
- Error and reset: writeback x12 while not pending -> out_error = 1, count stays 0. Assert reset low mid-cycle -> all outputs 0 asynchronously, before the next clock edge.
- Counter saturation with STALL_CNT_WIDTH = 4: hold a stall for 20 cycles -> out_stall_cycles = 15.

Source files
------------

// File: rtl/load_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// load_hazard_scoreboard
//
// Producer-side load-use interlock sitting between decode and the ID/EX
// register. It remembers which architectural registers are waiting for an
// in-flight load. The instruction in ID is held while it reads or overwrites
// such a register, or while it is a load and the tracker is full. EX-stage
// forwarding covers every other dependency.
//
// Ports
//   clk              pipeline clock
//   reset            asynchronous reset, active-low
//   in_issue_valid   ID holds a valid instruction
//   in_rs1/in_rs2    source registers; in_rs1_used/in_rs2_used qualify them
//   in_rd            destination register; in_reg_write qualifies it
//   in_is_load       ID instruction is a load
//   in_flush         squash the ID instruction (it neither stalls nor issues)
//   in_wb_valid      a load retires from MEM/WB; in_wb_rd is its destination
//   out_stall        hold PC and IF/ID, bubble into ID/EX (combinational)
//   out_pending      registered pending-load bit vector (bit 0 always 0)
//   out_outstanding  registered number of loads in flight
//   out_full         out_outstanding == MAX_OUTSTANDING
//   out_stall_cycles saturating count of stalled cycles
//   out_error        sticky: stray writeback or count underflow
// -----------------------------------------------------------------------------
module load_hazard_scoreboard #(
    parameter int REG_COUNT       = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs2,
    input  logic                       in_rs1_used,
    input  logic                       in_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
    input  logic                       in_reg_write,
    input  logic                       in_is_load,
    input  logic                       in_flush,
    input  logic                       in_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  in_wb_rd,
    output logic                       out_stall,
    output logic [REG_COUNT-1:0]       out_pending,
    output logic [3:0]                 out_outstanding,
    output logic                       out_full,
    output logic [STALL_CNT_WIDTH-1:0] out_stall_cycles,
    output logic                       out_error
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic                 rs1_hit;
    logic                 rs2_hit;
    logic                 rd_hit;
    logic                 cap_hit;
    logic                 hazard;
    logic                 accept;
    logic                 set_evt;
    logic                 wb_hit;
    logic                 clr_evt;
    logic                 wb_bad;
    logic [REG_COUNT-1:0] pending_next;

    // Hazard terms look only at registered state: a writeback in this cycle
    // does not release the stall until the next one.
    // NOTE: every always_comb output gets a default value first so that no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        rs1_hit  = 1'b0;
        rs2_hit  = 1'b0;
        rd_hit   = 1'b0;
        wb_hit   = 1'b0;
        if (in_rs1 != '0)   rs1_hit = in_rs1_used && out_pending[in_rs1];
        if (in_rs2 != '0)   rs2_hit = in_rs2_used && out_pending[in_rs2];
        if (in_rd != '0)    rd_hit  = in_reg_write && out_pending[in_rd];   // WAW
        if (in_wb_rd != '0) wb_hit  = in_wb_valid && out_pending[in_wb_rd];

        out_full  = (out_outstanding == MAX_CNT);
        cap_hit   = in_is_load && out_full;
        hazard    = rs1_hit || rs2_hit || rd_hit || cap_hit;

        // Flush wins over hazard: a squashed instruction neither stalls nor issues.
        out_stall = in_issue_valid && !in_flush && hazard;
        accept    = in_issue_valid && !in_flush && !hazard;
        set_evt   = accept && in_is_load && in_reg_write && (in_rd != '0);

        // A matching pending bit with a zero count means the state is corrupt;
        // hold the count and flag it rather than wrapping.
        clr_evt   = wb_hit && (out_outstanding != 4'd0);
        wb_bad    = in_wb_valid && !clr_evt;

        // The WAW term guarantees set and clear never name the same register.
        pending_next = out_pending;
        if (clr_evt) pending_next[in_wb_rd] = 1'b0;
        if (set_evt) pending_next[in_rd]    = 1'b1;
        pending_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pending      <= '0;
            out_outstanding  <= 4'd0;
            out_stall_cycles <= '0;
            out_error        <= 1'b0;
        end else begin
            out_pending <= pending_next;

            unique case ({set_evt, clr_evt})
                2'b10:   out_outstanding <= out_outstanding + 4'd1;
                2'b01:   out_outstanding <= out_outstanding - 4'd1;
                default: out_outstanding <= out_outstanding;
            endcase

            if (out_stall && (out_stall_cycles != {STALL_CNT_WIDTH{1'b1}}))
                out_stall_cycles <= out_stall_cycles + 1'b1;

            if (wb_bad)
                out_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Self-checking bench for load_hazard_scoreboard (MAX_OUTSTANDING = 4,
// STALL_CNT_WIDTH = 4 so counter saturation is reachable). A behavioural model
// keeps the set of registers awaiting a load; the in-flight count is the size
// of that set. Directed scenarios pin the model with literal values, then
// random traffic is compared against the model on every falling edge.
// -----------------------------------------------------------------------------
module tb_load_hazard_scoreboard;

    localparam int RC = 32;
    localparam int AW = 5;
    localparam int MO = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_issue_valid, in_rs1_used, in_rs2_used, in_reg_write;
    logic          in_is_load, in_flush, in_wb_valid;
    logic [AW-1:0] in_rs1, in_rs2, in_rd, in_wb_rd;
    logic          out_stall, out_full, out_error;
    logic [RC-1:0] out_pending;
    logic [3:0]    out_outstanding;
    logic [SW-1:0] out_stall_cycles;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Behavioural model state
    logic [RC-1:0] m_pend = '0;
    bit            m_err  = 1'b0;
    int            m_scnt = 0;

    load_hazard_scoreboard #(
        .REG_COUNT(RC), .REG_ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_issue_valid(in_issue_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_flush(in_flush), .in_wb_valid(in_wb_valid), .in_wb_rd(in_wb_rd),
        .out_stall(out_stall), .out_pending(out_pending),
        .out_outstanding(out_outstanding), .out_full(out_full),
        .out_stall_cycles(out_stall_cycles), .out_error(out_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_stall();
        bit h;
        h = 1'b0;
        if (in_rs1_used && in_rs1 != 0 && m_pend[in_rs1]) h = 1'b1;
        if (in_rs2_used && in_rs2 != 0 && m_pend[in_rs2]) h = 1'b1;
        if (in_reg_write && in_rd != 0 && m_pend[in_rd])  h = 1'b1;
        if (in_is_load && $countones(m_pend) == MO)        h = 1'b1;
        return in_issue_valid && !in_flush && h;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_pend = '0;
                m_err  = 1'b0;
                m_scnt = 0;
            end else begin
                bit st;
                bit issue_load;
                st = m_stall();
                issue_load = in_issue_valid && !in_flush && !st && in_is_load
                             && in_reg_write && in_rd != 0;
                if (in_wb_valid) begin
                    if (in_wb_rd != 0 && m_pend[in_wb_rd]) m_pend[in_wb_rd] = 1'b0;
                    else m_err = 1'b1;
                end
                if (issue_load) m_pend[in_rd] = 1'b1;
                if (st && m_scnt < (1 << SW) - 1) m_scnt++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("stall",       64'(out_stall),        64'(m_stall()));
                check("pending",     64'(out_pending),      64'(m_pend));
                check("outstanding", 64'(out_outstanding),  64'($countones(m_pend)));
                check("full",        64'(out_full),         64'($countones(m_pend) == MO));
                check("stall_cycles",64'(out_stall_cycles), 64'(m_scnt));
                check("error",       64'(out_error),        64'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        in_issue_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
        in_rd = 0; in_reg_write = 0; in_is_load = 0; in_flush = 0;
        in_wb_valid = 0; in_wb_rd = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int rd);
        idle();
        in_issue_valid = 1; in_rd = AW'(rd); in_reg_write = 1; in_is_load = 1;
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        idle();
        in_issue_valid = 1; in_rd = AW'(rd); in_reg_write = 1;
        in_rs1 = AW'(rs1); in_rs1_used = 1; in_rs2 = AW'(rs2); in_rs2_used = 1;
    endtask

    // Leaves the bench just after a rising edge, ready to drive inputs.
    task automatic do_reset();
        idle();
        reset = 0;
        step();
        @(negedge clk);
        #2 reset = 1;
        step();
    endtask

    initial begin
        idle();
        #7 reset = 1;
        step();
        checking = 1'b1;

        // ---- load-use ----
        do_reset();
        load(5);            @(negedge clk); check("lu_load_nostall", 64'(out_stall), 0); step();
        alu(6, 5, 1);       @(negedge clk); check("lu_use_stall", 64'(out_stall), 1);
                            check("lu_pending_x5", 64'(out_pending), 64'h20); step();
        in_wb_valid = 1; in_wb_rd = 5;
                            @(negedge clk); check("lu_wb_still_stall", 64'(out_stall), 1); step();
        in_wb_valid = 0;    @(negedge clk); check("lu_release", 64'(out_stall), 0);
                            check("lu_stall_cycles", 64'(out_stall_cycles), 2); step();
        idle();

        // ---- capacity ----
        do_reset();
        for (int r = 1; r <= 4; r++) begin load(r); step(); end
        idle();             @(negedge clk); check("cap_full", 64'(out_full), 1);
                            check("cap_count4", 64'(out_outstanding), 4);
        load(7);            #1 check("cap_fifth_stall", 64'(out_stall), 1);
        step();
        in_wb_valid = 1; in_wb_rd = 2;
                            @(negedge clk); check("cap_wb_same_cycle_stall", 64'(out_stall), 1); step();
        in_wb_valid = 0;    @(negedge clk); check("cap_released", 64'(out_stall), 0);
                            check("cap_count3", 64'(out_outstanding), 3); step();
        idle();             @(negedge clk); check("cap_count_back4", 64'(out_outstanding), 4);
                            check("cap_pending", 64'(out_pending), 64'h9A); step();

        // ---- zero register and unused source ----
        do_reset();
        load(0);            step();
        idle();             @(negedge clk); check("x0_no_pending", 64'(out_pending), 0);
                            check("x0_count0", 64'(out_outstanding), 0); step();
        load(3);            step();
        alu(4, 0, 3); in_rs2_used = 0;
                            @(negedge clk); check("rs2_unused_nostall", 64'(out_stall), 0); step();
        idle();

        // ---- WAW and flush ----
        do_reset();
        load(9);            step();
        load(9);            @(negedge clk); check("waw_stall", 64'(out_stall), 1);
        in_flush = 1;       #1 check("flush_nostall", 64'(out_stall), 0); step();
        idle();             @(negedge clk); check("flush_no_state", 64'(out_pending), 64'h200);
                            check("flush_count1", 64'(out_outstanding), 1); step();
        load(10); in_wb_valid = 1; in_wb_rd = 9; step();
        idle();             @(negedge clk); check("setclr_pending", 64'(out_pending), 64'h400);
                            check("setclr_count", 64'(out_outstanding), 1); step();

        // ---- error and asynchronous reset ----
        do_reset();
        idle(); in_wb_valid = 1; in_wb_rd = 12; step();
        idle();             @(negedge clk); check("err_set", 64'(out_error), 1);
                            check("err_count0", 64'(out_outstanding), 0); step();
        load(4);            step();
        alu(6, 4, 0);       @(negedge clk); check("pre_rst_stall", 64'(out_stall), 1);
        #2 reset = 0;
        #1;
        check("rst_stall",   64'(out_stall), 0);
        check("rst_pending", 64'(out_pending), 0);
        check("rst_count",   64'(out_outstanding), 0);
        check("rst_full",    64'(out_full), 0);
        check("rst_scnt",    64'(out_stall_cycles), 0);
        check("rst_error",   64'(out_error), 0);
        idle();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1;
        step();
        in_wb_valid = 1; in_wb_rd = 4; step();
        idle();             @(negedge clk); check("stale_wb_error", 64'(out_error), 1); step();

        // ---- counter saturation ----
        do_reset();
        load(8);            step();
        alu(1, 8, 8);
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);     check("scnt_saturated", 64'(out_stall_cycles), 15); step();
        idle();

        // ---- randomized traffic ----
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 97 == 96) do_reset();
            idle();
            in_issue_valid = ($urandom_range(0, 99) < 80);
            in_rs1       = AW'($urandom_range(0, 7));
            in_rs2       = AW'($urandom_range(0, 7));
            in_rd        = AW'($urandom_range(0, 7));
            in_rs1_used  = 1'($urandom_range(0, 1));
            in_rs2_used  = 1'($urandom_range(0, 1));
            in_reg_write = ($urandom_range(0, 99) < 85);
            in_is_load   = ($urandom_range(0, 99) < 50);
            in_flush     = ($urandom_range(0, 99) < 10);
            if (m_pend != 0 && $urandom_range(0, 99) < 40) begin
                int k;
                do k = $urandom_range(1, RC - 1); while (!m_pend[k]);
                in_wb_valid = 1; in_wb_rd = AW'(k);
            end else if ($urandom_range(0, 99) < 3) begin
                in_wb_valid = 1; in_wb_rd = AW'($urandom_range(0, 7));
            end
            step();
        end
        idle();
        step();
        @(negedge clk);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
